// File: rtl/axi_regs_pkg.sv
// Shared encodings for the MAXIGP0 register-file slave: AXI response and
// burst codes, the transaction FSM states and the arbiter grant encoding.
package axi_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        BRSP = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    // Word address of the next beat. FIXED stays put; INCR, WRAP and the
    // reserved code all step by one word. The carry is allowed to run into
    // the upper address bits so that range checks see the true beat address,
    // while the register index (the low bits) simply wraps modulo NREGS.
    function automatic logic [29:0] next_word_addr(input logic [29:0] addr,
                                                   input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + 30'd1;
    endfunction

endpackage

// File: rtl/axi_regs_arb.sv
// Two-way round-robin arbiter between the AXI read and write address
// channels. A lone request wins outright; on a tie the channel that was not
// granted last wins. The history flop resets to "write", so the first tie
// after reset goes to the read channel.
module axi_regs_arb
    import axi_regs_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic req_rd,
    input  logic req_wr,
    input  logic advance,
    output logic gnt_rd,
    output logic gnt_wr
);

    grant_t r_last_grant;

    assign gnt_rd = req_rd && (!req_wr || (r_last_grant == GRANT_WR));
    assign gnt_wr = req_wr && !gnt_rd;

    // Remember which channel won whenever a grant is actually consumed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= GRANT_WR;
        end else if (advance && (gnt_rd || gnt_wr)) begin
            r_last_grant <= gnt_rd ? GRANT_RD : GRANT_WR;
        end
    end

endmodule

// File: rtl/axi_gp_regs.sv
// AXI3 slave for the PS7 MAXIGP0 port backed by an NREGS x 32-bit register
// bank. One transaction is in flight at a time; read and write address
// channels share the bank through a round-robin arbiter. The full register
// contents are exported on reg_q for fabric use.
// Optional feature: define AXI_REGS_SLVERR_EN to flag beats whose address
// lies above the register window with SLVERR (reads return zero, writes are
// dropped). Without it, upper address bits are ignored and all responses
// are OKAY.
module axi_gp_regs
    import axi_regs_pkg::*;
#(
    parameter int          NREGS   = 16,
    parameter int          ID_W    = 12,
    parameter logic [31:0] RST_VAL = 32'h5555_5555
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [ID_W-1:0]       ar_id,
    input  logic [31:0]           ar_addr,
    input  logic [3:0]            ar_len,
    input  logic [1:0]            ar_burst,
    input  logic                  ar_valid,
    output logic                  ar_ready,

    output logic [ID_W-1:0]       r_id,
    output logic [31:0]           r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  r_valid,
    input  logic                  r_ready,

    input  logic [ID_W-1:0]       aw_id,
    input  logic [31:0]           aw_addr,
    input  logic [3:0]            aw_len,
    input  logic [1:0]            aw_burst,
    input  logic                  aw_valid,
    output logic                  aw_ready,

    input  logic [31:0]           w_data,
    input  logic [3:0]            w_strb,
    input  logic                  w_last,
    input  logic                  w_valid,
    output logic                  w_ready,

    output logic [ID_W-1:0]       b_id,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,

    output logic [NREGS*32-1:0]   reg_q
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Transaction context latched at the address handshake.
    state_t            r_state;
    logic [ID_W-1:0]   r_txn_id;
    logic [29:0]       r_word_addr;
    logic [1:0]        r_burst;
    logic [3:0]        r_beats;
    logic              r_rvalid;
    logic              r_rlast;
    logic              r_wready;
    logic              r_bvalid;
    logic              r_berr;

    logic              w_gnt_rd;
    logic              w_gnt_wr;
    logic              w_idle;
    logic              w_advance;
    logic [IDX_W-1:0]  w_index;
    logic              w_oor;
    logic              w_we;
    logic [29:0]       w_next_addr;
    logic [31:0]       w_regs [NREGS];

    // Byte-lane offsets and w_last carry no information for this slave: the
    // bank is word-addressed and the latched beat count ends the burst.
    logic              w_unused;
    assign w_unused = &{1'b0, ar_addr[1:0], aw_addr[1:0], w_last};

    assign w_idle      = (r_state == IDLE);
    assign w_advance   = w_idle && (ar_valid || aw_valid);
    assign w_index     = r_word_addr[IDX_W-1:0];
    assign w_next_addr = next_word_addr(r_word_addr, r_burst);

`ifdef AXI_REGS_SLVERR_EN
    // Any set bit above the register window marks this beat out of range.
    assign w_oor = |r_word_addr[29:IDX_W];
`else
    assign w_oor = 1'b0;
`endif

    axi_regs_arb u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req_rd  (ar_valid),
        .req_wr  (aw_valid),
        .advance (w_advance),
        .gnt_rd  (w_gnt_rd),
        .gnt_wr  (w_gnt_wr)
    );

    assign ar_ready = w_idle && w_gnt_rd;
    assign aw_ready = w_idle && w_gnt_wr;

    // Transaction sequencer: address capture, R beats, W beats, B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_txn_id    <= '0;
            r_word_addr <= '0;
            r_burst     <= BURST_FIXED;
            r_beats     <= '0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_berr      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_rd) begin
                        r_state     <= RD;
                        r_txn_id    <= ar_id;
                        r_word_addr <= ar_addr[31:2];
                        r_burst     <= ar_burst;
                        r_beats     <= ar_len;
                        r_rvalid    <= 1'b1;
                        r_rlast     <= (ar_len == 4'd0);
                    end else if (w_gnt_wr) begin
                        r_state     <= WR;
                        r_txn_id    <= aw_id;
                        r_word_addr <= aw_addr[31:2];
                        r_burst     <= aw_burst;
                        r_beats     <= aw_len;
                        r_wready    <= 1'b1;
                        r_berr      <= 1'b0;
                    end
                end
                RD: begin
                    if (r_ready) begin
                        if (r_beats == 4'd0) begin
                            r_state  <= IDLE;
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                        end else begin
                            r_beats     <= r_beats - 4'd1;
                            r_word_addr <= w_next_addr;
                            r_rlast     <= (r_beats == 4'd1);
                        end
                    end
                end
                WR: begin
                    if (w_valid) begin
                        if (w_oor) begin
                            r_berr <= 1'b1;
                        end
                        if (r_beats == 4'd0) begin
                            r_state  <= BRSP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                        end else begin
                            r_beats     <= r_beats - 4'd1;
                            r_word_addr <= w_next_addr;
                        end
                    end
                end
                BRSP: begin
                    if (b_ready) begin
                        r_state  <= IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_we = (r_state == WR) && w_valid && !w_oor;

    // Register bank: one word per generate slice with per-byte write enables.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [31:0] r_q;

            // Byte-masked update of this word when the write beat targets it.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_q <= RST_VAL;
                end else if (w_we && (w_index == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) begin
                            r_q[8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                end
            end

            assign w_regs[gi]          = r_q;
            assign reg_q[32*gi +: 32]  = r_q;
        end
    endgenerate

    // Read data is a mux of the bank; the bank cannot change while a read
    // burst is active, so the beat stays stable across r_ready stalls.
    assign r_valid = r_rvalid;
    assign r_last  = r_rlast;
    assign r_id    = r_txn_id;
    assign r_data  = (r_rvalid && !w_oor) ? w_regs[w_index] : 32'd0;
    assign r_resp  = (r_rvalid && w_oor) ? RESP_SLVERR : RESP_OKAY;

    assign w_ready = r_wready;

    assign b_valid = r_bvalid;
    assign b_id    = r_txn_id;
    assign b_resp  = (r_bvalid && r_berr) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_gp_regs.sv
// Directed bench for axi_gp_regs: single-beat write/read vectors from a
// table, then hand-written bursts, stalls, arbitration ties and reset.
module tb_axi_gp_regs;

    localparam int          NREGS = 16;
    localparam int          ID_W  = 12;
    localparam logic [31:0] RSTV  = 32'h5555_5555;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [ID_W-1:0]       ar_id = '0;
    logic [31:0]           ar_addr = '0;
    logic [3:0]            ar_len = '0;
    logic [1:0]            ar_burst = '0;
    logic                  ar_valid = 1'b0;
    logic                  ar_ready;
    logic [ID_W-1:0]       r_id;
    logic [31:0]           r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready = 1'b0;
    logic [ID_W-1:0]       aw_id = '0;
    logic [31:0]           aw_addr = '0;
    logic [3:0]            aw_len = '0;
    logic [1:0]            aw_burst = '0;
    logic                  aw_valid = 1'b0;
    logic                  aw_ready;
    logic [31:0]           w_data = '0;
    logic [3:0]            w_strb = '0;
    logic                  w_last = 1'b0;
    logic                  w_valid = 1'b0;
    logic                  w_ready;
    logic [ID_W-1:0]       b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready = 1'b0;
    logic [NREGS*32-1:0]   reg_q;

    axi_gp_regs #(.NREGS(NREGS), .ID_W(ID_W), .RST_VAL(RSTV)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
        .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .reg_q(reg_q)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]     wr_data [16];
    logic [31:0]     rd_data [16];
    logic            rd_last [16];
    logic [1:0]      rd_resp [16];
    logic [ID_W-1:0] rd_id;
    logic [1:0]      got_bresp;
    logic [ID_W-1:0] got_bid;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        int          ridx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [ID_W-1:0] id,
                            input bit stall);
        int guard;
        logic [47:0] snap;
        @(negedge aclk);
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
        #1;
        guard = 0;
        while (!ar_ready && guard < 20) begin
            @(negedge aclk); #1; guard++;
        end
        chk("ar_ready", 64'(ar_ready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        ar_valid = 1'b0;
        chk("r_valid_at_T+1", 64'(r_valid), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            if (stall) begin
                r_ready = 1'b0;
                snap = {r_valid, r_last, r_resp, r_id, r_data};
                @(posedge aclk);
                @(negedge aclk);
                chk("stall_stable", 64'({r_valid, r_last, r_resp, r_id, r_data}), 64'(snap));
            end
            r_ready    = 1'b1;
            rd_data[b] = r_data;
            rd_last[b] = r_last;
            rd_resp[b] = r_resp;
            rd_id      = r_id;
            chk("r_valid_beat", 64'(r_valid), 64'd1);
            @(posedge aclk);
            @(negedge aclk);
            r_ready = 1'b0;
        end
        chk("r_valid_after", 64'(r_valid), 64'd0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [ID_W-1:0] id,
                             input logic [3:0] strb);
        int guard;
        @(negedge aclk);
        aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
        #1;
        guard = 0;
        while (!aw_ready && guard < 20) begin
            @(negedge aclk); #1; guard++;
        end
        chk("aw_ready", 64'(aw_ready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        aw_valid = 1'b0;
        chk("w_ready_at_T+1", 64'(w_ready), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            w_valid = 1'b1; w_data = wr_data[b]; w_strb = strb;
            w_last  = (b == int'(len));
            @(posedge aclk);
            @(negedge aclk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk("b_valid_at_U+1", 64'(b_valid), 64'd1);
        got_bresp = b_resp;
        got_bid   = b_id;
        b_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        b_ready = 1'b0;
        chk("b_valid_after", 64'(b_valid), 64'd0);
    endtask

    // Both address channels raised together; expect_rd says who should win.
    task automatic tie_txn(input bit expect_rd, input logic [31:0] wdat);
        @(negedge aclk);
        ar_id = 12'h0A1; ar_addr = 32'h20; ar_len = 4'd0; ar_burst = 2'b01; ar_valid = 1'b1;
        aw_id = 12'h0B2; aw_addr = 32'h24; aw_len = 4'd0; aw_burst = 2'b01; aw_valid = 1'b1;
        #1;
        chk("tie_ar_ready", 64'(ar_ready), 64'(expect_rd));
        chk("tie_aw_ready", 64'(aw_ready), 64'(!expect_rd));
        @(posedge aclk);
        @(negedge aclk);
        ar_valid = 1'b0; aw_valid = 1'b0;
        if (expect_rd) begin
            chk("tie_r_valid", 64'(r_valid), 64'd1);
            chk("tie_r_data", 64'(r_data), 64'(RSTV));
            chk("tie_r_id", 64'(r_id), 64'h0A1);
            r_ready = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            r_ready = 1'b0;
        end else begin
            chk("tie_w_ready", 64'(w_ready), 64'd1);
            w_valid = 1'b1; w_data = wdat; w_strb = 4'hF; w_last = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            w_valid = 1'b0; w_last = 1'b0;
            chk("tie_b_valid", 64'(b_valid), 64'd1);
            chk("tie_b_id", 64'(b_id), 64'h0B2);
            b_ready = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            b_ready = 1'b0;
            chk("tie_reg9", 64'(reg_q[32*9 +: 32]), 64'(wdat));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h08, 32'hDEADBEEF, 4'b0101, 32'h08, 2,  32'h55AD55EF};
        vecs[1] = '{32'h0C, 32'h12345678, 4'b1111, 32'h0C, 3,  32'h12345678};
        vecs[2] = '{32'h10, 32'hAABBCCDD, 4'b1000, 32'h10, 4,  32'hAA555555};
        vecs[3] = '{32'h14, 32'h01020304, 4'b0000, 32'h14, 5,  32'h55555555};
        vecs[4] = '{32'h3C, 32'hCAFEF00D, 4'b0011, 32'h3C, 15, 32'h5555F00D};
        vecs[5] = '{32'h00, 32'h11223344, 4'b1111, 32'h00, 0,  32'h11223344};
        vecs[6] = '{32'h1B, 32'hA5A5A5A5, 4'b0110, 32'h18, 6,  32'h55A5A555};

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_last", 64'(r_last), 64'd0);
        chk("rst_r_data", 64'(r_data), 64'd0);
        chk("rst_r_id", 64'(r_id), 64'd0);
        chk("rst_r_resp", 64'(r_resp), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_id", 64'(b_id), 64'd0);
        chk("rst_b_resp", 64'(b_resp), 64'd0);
        for (int k = 0; k < NREGS; k++) chk("rst_reg", 64'(reg_q[32*k +: 32]), 64'(RSTV));
        @(negedge aclk);
        aresetn = 1'b1;

        // First read after reset
        axi_read(32'h0, 4'd0, 2'b01, 12'h123, 1'b0);
        chk("rd0_data", 64'(rd_data[0]), 64'(RSTV));
        chk("rd0_last", 64'(rd_last[0]), 64'd1);
        chk("rd0_resp", 64'(rd_resp[0]), 64'd0);
        chk("rd0_id", 64'(rd_id), 64'h123);

        // Single-beat write / read vectors
        for (int v = 0; v < 7; v++) begin
            wr_data[0] = vecs[v].wdata;
            axi_write(vecs[v].waddr, 4'd0, 2'b01, 12'(v + 16), vecs[v].wstrb);
            chk("vec_b_resp", 64'(got_bresp), 64'd0);
            chk("vec_b_id", 64'(got_bid), 64'(v + 16));
            chk("vec_reg_q", 64'(reg_q[32*vecs[v].ridx +: 32]), 64'(vecs[v].exp));
            axi_read(vecs[v].raddr, 4'd0, 2'b01, 12'(v + 32), 1'b0);
            chk("vec_r_data", 64'(rd_data[0]), 64'(vecs[v].exp));
            chk("vec_r_last", 64'(rd_last[0]), 64'd1);
            chk("vec_r_resp", 64'(rd_resp[0]), 64'd0);
        end

        // INCR burst write then stalled INCR burst read
        wr_data[0] = 32'd1; wr_data[1] = 32'd2; wr_data[2] = 32'd3; wr_data[3] = 32'd4;
        axi_write(32'h4, 4'd3, 2'b01, 12'h345, 4'hF);
        chk("incr_b_resp", 64'(got_bresp), 64'd0);
        for (int k = 0; k < 4; k++) chk("incr_reg_q", 64'(reg_q[32*(k+1) +: 32]), 64'(k + 1));
        axi_read(32'h4, 4'd3, 2'b01, 12'h346, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("incr_r_data", 64'(rd_data[k]), 64'(k + 1));
            chk("incr_r_last", 64'(rd_last[k]), 64'(k == 3));
        end

        // FIXED burst: both beats hit reg 7, last one wins
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        axi_write(32'h1C, 4'd1, 2'b00, 12'h050, 4'hF);
        chk("fixed_reg7", 64'(reg_q[32*7 +: 32]), 64'h22222222);
        chk("fixed_reg8", 64'(reg_q[32*8 +: 32]), 64'(RSTV));
        axi_read(32'h1C, 4'd1, 2'b00, 12'h051, 1'b0);
        chk("fixed_rd0", 64'(rd_data[0]), 64'h22222222);
        chk("fixed_rd1", 64'(rd_data[1]), 64'h22222222);
        chk("fixed_last0", 64'(rd_last[0]), 64'd0);
        chk("fixed_last1", 64'(rd_last[1]), 64'd1);

        // INCR read wrapping from reg 15 to reg 0
        axi_read(32'h3C, 4'd1, 2'b01, 12'h060, 1'b0);
        chk("wrap_rd0", 64'(rd_data[0]), 64'h5555F00D);
        chk("wrap_rd1", 64'(rd_data[1]), 64'h11223344);

        // Upper address bits
        axi_read(32'h100, 4'd0, 2'b01, 12'h070, 1'b0);
`ifdef AXI_REGS_SLVERR_EN
        chk("oor_r_data", 64'(rd_data[0]), 64'd0);
        chk("oor_r_resp", 64'(rd_resp[0]), 64'd2);
`else
        chk("oor_r_data", 64'(rd_data[0]), 64'h11223344);
        chk("oor_r_resp", 64'(rd_resp[0]), 64'd0);
`endif

        // Reset in the middle of a 4-beat read
        @(negedge aclk);
        ar_id = 12'h080; ar_addr = 32'h4; ar_len = 4'd3; ar_burst = 2'b01; ar_valid = 1'b1;
        #1;
        chk("mid_ar_ready", 64'(ar_ready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("mid_r_valid", 64'(r_valid), 64'd1);
        chk("mid_r_data", 64'(r_data), 64'd2);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_r_valid", 64'(r_valid), 64'd0);
        chk("async_r_last", 64'(r_last), 64'd0);
        for (int k = 0; k < NREGS; k++) chk("async_reg", 64'(reg_q[32*k +: 32]), 64'(RSTV));
        r_ready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("post_rst_r_valid", 64'(r_valid), 64'd0);
        chk("post_rst_b_valid", 64'(b_valid), 64'd0);

        // Three ties after reset: read, write, read
        tie_txn(1'b1, 32'h0);
        tie_txn(1'b0, 32'h0BADF00D);
        tie_txn(1'b1, 32'h0);

        repeat (2) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_gp_regs.md
# axi_gp_regs

AXI3 slave controller for the PS7 MAXIGP0 general-purpose port: it accepts read and write bursts from the PS, arbitrates the single shared register-file port between the read and write channels, and sequences R beats and B responses. It replaces the fixed-data read stub with a real NREGS×32-bit register bank. The register contents are also exported to fabric logic (LEDs, control bits).

## Interface
- NREGS, 16, number of 32-bit registers; power of two, 2..256
- ID_W, 12, AXI ID width (MAXIGP0 = 12)
- RST_VAL, 32'h5555_5555, reset value of every register
- aclk  in  1  MAXIGP0ACLK, driven from FCLKCLK[0]
- aresetn  in  1  MAXIGP0ARESETN; **one clock; reset is asynchronous and active-low**
- ar_id / ar_addr / ar_len / ar_burst / ar_valid  in  ID_W/32/4/2/1  read address channel
- ar_ready  out  1  read address accept
- r_id / r_data / r_resp / r_last / r_valid  out  ID_W/32/2/1/1  read data channel
- r_ready  in  1  PS accepts the R beat
- aw_id / aw_addr / aw_len / aw_burst / aw_valid  in  ID_W/32/4/2/1  write address channel
- aw_ready  out  1  write address accept
- w_data / w_strb / w_last / w_valid  in  32/4/1/1  write data channel
- w_ready  out  1  write data accept
- b_id / b_resp / b_valid  out  ID_W/2/1  write response
- b_ready  in  1  PS accepts B
- reg_q  out  NREGS*32  flat register contents; reg k at [32k+31:32k]

## Operation
- FSM states: IDLE, RD, WR, BRSP. One transaction in flight at a time.
- IDLE arbitration: only ar_valid → grant read; only aw_valid → grant write; both → grant the channel not granted last (round-robin). last_grant resets to WRITE, so read wins the first tie.
- ar_ready = IDLE && read granted; aw_ready = IDLE && write granted (combinational from the registered state and the valids). The handshake latches id, index = addr[log2(NREGS)+1:2], burst, and beats = len. addr[1:0] are ignored.
- Burst: FIXED (2'b00) keeps the index; INCR (2'b01) and WRAP (2'b10) increment the index by 1 per beat, modulo NREGS. Reserved 2'b11 is treated as INCR.
- RD: r_valid=1; r_data=regs[index], r_id=latched id, r_resp=OKAY, r_last=(beats==0). On r_valid&&r_ready: if beats==0 → IDLE, else beats−1 and advance index. r_* outputs stay stable while r_ready is low.
- WR: w_ready=1. On w_valid&&w_ready, write the bytes of regs[index] selected by w_strb[i]. If beats==0 → BRSP, else decrement and advance. The internal count governs the burst; w_last is ignored.
- BRSP: b_valid=1, b_id=latched id, b_resp per Configuration. On b_ready → IDLE.
- A read issued after the B handshake observes all bytes written by that burst.

## Timing
- Reset (async assert, sync release): state=IDLE; all ready/valid/last outputs 0; r_data, r_id, b_id, and resp outputs 0; all regs=RST_VAL; last_grant=WRITE. Assertion mid-burst abandons the transaction immediately, with no B or remaining R beats.
- Read latency: AR handshake at cycle T → first r_valid at T+1. With r_ready held high, one beat per cycle; ar_ready is high again at the cycle after the last beat.
- Write: AW handshake at T → w_ready at T+1. After the last W beat at cycle U, b_valid is high at U+1. reg_q reflects each beat at the next edge.
- Minimum turnaround between transactions: 1 IDLE cycle.

## Configuration
- AXI_REGS_SLVERR_EN defined: a beat whose addr[31:log2(NREGS)+2] ≠ 0 (evaluated per beat, using the start address plus the beat offset) is out of range.
  - Out-of-range read beats return r_data=0 and r_resp=2'b10.
  - Out-of-range write beats are discarded, and b_resp=2'b10 if any beat of the burst was out of range.
- Undefined: upper address bits are ignored, the index wraps modulo NREGS, and all responses are OKAY (2'b00).

## Structure
- Package axi_regs_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - BURST_FIXED/INCR/WRAP encodings
  - the state enum {IDLE,RD,WR,BRSP}
- Sub-module axi_regs_arb: 2-way round-robin arbiter (req_rd, req_wr, advance → gnt_rd, gnt_wr), containing the last_grant flop.

## Test plan
- After reset release: single read ar_addr=0x0, len=0 → r_data=32'h5555_5555, r_last=1, r_resp=0, r_valid at T+1.
- Write addr=0x8, len=0, w_data=0xDEADBEEF, w_strb=4'b0101 → b_valid with b_resp=0; a later read of 0x8 returns 0x55AD55EF, and reg_q[95:64] matches.
- INCR write len=3 at 0x4 with data 1,2,3,4, then INCR read len=3 at 0x4 with r_ready toggled every other cycle → data 1,2,3,4, r_last only on beat 4, outputs stable while stalled.
- ar_valid and aw_valid asserted together in three consecutive transactions → grants in the order read, write, read.
- With AXI_REGS_SLVERR_EN, read of 0x100 (NREGS=16) → r_data=0, r_resp=2'b10. Without the macro, the same read returns regs[0].
- aresetn pulsed low in the middle of a 4-beat read → r_valid drops to 0 asynchronously, regs return to RST_VAL, and the next AR is accepted normally.
